// File: rtl/stream_mux2to1_rr_if.sv
// Bundle of the two producer streams and the merged, source-tagged consumer stream.
// master = environment (producers + consumer), slave = the merging mux.
interface stream_mux2to1_rr_if #(
  parameter int WIDTH = 8
);
  logic             in0_valid;
  logic [WIDTH-1:0] in0_data;
  logic             in0_ready;
  logic             in1_valid;
  logic [WIDTH-1:0] in1_data;
  logic             in1_ready;
  logic             out_valid;
  logic [WIDTH-1:0] out_data;
  logic             out_sel;
  logic             out_ready;

  modport master (
    output in0_valid, in0_data, input in0_ready,
    output in1_valid, in1_data, input in1_ready,
    input  out_valid, out_data, out_sel, output out_ready
  );

  modport slave (
    input  in0_valid, in0_data, output in0_ready,
    input  in1_valid, in1_data, output in1_ready,
    output out_valid, out_data, out_sel, input out_ready
  );
endinterface

// File: rtl/stream_mux2to1_rr.sv
// Round-robin 2:1 valid/ready merge into one registered stage; each word is
// tagged with its source index so a downstream demux can split it again.
module stream_mux2to1_rr #(
  parameter int WIDTH = 8
) (
  input logic                clk,
  input logic                rst_n,
  stream_mux2to1_rr_if.slave bus
);
  logic [1:0]            req;
  logic [1:0][WIDTH-1:0] in_data;
  logic [1:0]            rdy;
  logic                  load_en;
  logic                  grant_vld;
  logic                  grant;
  logic                  xfer;
  logic                  last_grant;
  logic                  out_valid_q;
  logic [WIDTH-1:0]      out_data_q;
  logic                  out_sel_q;

  assign req     = {bus.in1_valid, bus.in0_valid};
  assign in_data = {bus.in1_data, bus.in0_data};

  // Empty, or draining this cycle: refill in the same cycle for full rate.
  assign load_en = !out_valid_q || bus.out_ready;

  always_comb begin
    grant_vld = |req;
    grant     = (&req) ? ~last_grant : req[1];
  end

  // Ready only to the granted requester, so readies are mutually exclusive.
  assign rdy[0] = rst_n && load_en && grant_vld && !grant;
  assign rdy[1] = rst_n && load_en && grant_vld &&  grant;
  assign xfer   = grant_vld && load_en;

  assign bus.in0_ready = rdy[0];
  assign bus.in1_ready = rdy[1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_sel_q   <= 1'b0;
      last_grant  <= 1'b1;
    end else if (xfer) begin
      out_valid_q <= 1'b1;
      out_data_q  <= in_data[grant];
      out_sel_q   <= grant;
      last_grant  <= grant;
    end else if (bus.out_ready) begin
      out_valid_q <= 1'b0;
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_sel   = out_sel_q;
endmodule
